// File: rtl/mult_hilo_ctrl.sv
// Sequencer between the control unit and the Booth multiplier: starts an op,
// captures the product into HI/LO on its single valid cycle, and serves MTHI/MTLO.
module mult_hilo_ctrl #(
    parameter int unsigned MULT_CYCLES = 32,
    parameter int unsigned MAX_WAIT    = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mult_req,
    input  logic        hi_write,
    input  logic        lo_write,
    input  logic [31:0] reg_in,
    input  logic [31:0] msb_prod,
    input  logic [31:0] lsb_prod,
    input  logic        calculando,
    output logic        mult_start,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        mult_done,
    output logic        mult_erro
);

    // Counter must cover both the nominal wait and the watchdog limit.
    localparam int unsigned CNT_MAX = (MAX_WAIT > MULT_CYCLES + 1) ? MAX_WAIT : MULT_CYCLES + 1;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    // calculando is only trusted in S_WAIT; the multiplier has no reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            hi_out     <= '0;
            lo_out     <= '0;
            mult_start <= 1'b0;
            busy       <= 1'b0;
            mult_done  <= 1'b0;
            mult_erro  <= 1'b0;
        end else begin
            mult_start <= 1'b0;
            mult_done  <= 1'b0;
            mult_erro  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mult_req) begin
                        state      <= S_START;
                        mult_start <= 1'b1;
                        busy       <= 1'b1;
                    end else begin
                        if (hi_write) hi_out <= reg_in;
                        if (lo_write) lo_out <= reg_in;
                    end
                end
                S_START: begin
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (!calculando) begin
                        hi_out    <= msb_prod;
                        lo_out    <= lsb_prod;
                        state     <= S_DONE;
                        mult_done <= 1'b1;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state     <= S_ERR;
                        mult_erro <= 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed bench for mult_hilo_ctrl with a cycle-exact multiplier model.
module tb_mult_hilo_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mult_req;
    logic        hi_write;
    logic        lo_write;
    logic [31:0] reg_in;
    logic [31:0] msb_prod;
    logic [31:0] lsb_prod;
    logic        calculando;
    logic        mult_start;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        mult_done;
    logic        mult_erro;

    always #5 clk = ~clk;

    mult_hilo_ctrl dut (
        .clk(clk), .reset(reset), .mult_req(mult_req), .hi_write(hi_write),
        .lo_write(lo_write), .reg_in(reg_in), .msb_prod(msb_prod), .lsb_prod(lsb_prod),
        .calculando(calculando), .mult_start(mult_start), .hi_out(hi_out), .lo_out(lo_out),
        .busy(busy), .mult_done(mult_done), .mult_erro(mult_erro)
    );

    // Multiplier model: no reset, product valid only at count 32, garbage elsewhere.
    logic signed [31:0] op_a = 32'sd0;
    logic signed [31:0] op_b = 32'sd0;
    logic signed [31:0] pa = 32'sd0;
    logic signed [31:0] pb = 32'sd0;
    logic signed [63:0] prod;
    int                 cnt_m = 40;
    logic               stuck = 1'b0;

    always @(posedge clk) begin
        if (mult_start) begin
            cnt_m <= 0;
            pa    <= op_a;
            pb    <= op_b;
        end else if (cnt_m < 1000) begin
            cnt_m <= cnt_m + 1;
        end
    end

    assign prod       = pa * pb;
    assign msb_prod   = (cnt_m == 32) ? prod[63:32] : ~prod[63:32];
    assign lsb_prod   = (cnt_m == 32) ? prod[31:0]  : ~prod[31:0];
    assign calculando = stuck || (cnt_m < 32);

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request; sample index n means "just after edge n", edge 0 samples the request.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int done_at, output int done_cnt, output int busy_cnt,
                          output int start_at, output int start_cnt, output int erro_at);
        done_at = -1; done_cnt = 0; busy_cnt = 0;
        start_at = -1; start_cnt = 0; erro_at = -1;
        op_a = a;
        op_b = b;
        mult_req = 1'b1;
        for (int n = 0; n < 120; n++) begin
            step();
            if (n == 0) begin
                mult_req = 1'b0;
                hi_write = 1'b0;
                lo_write = 1'b0;
            end
            if (busy) busy_cnt++;
            if (mult_done) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (mult_start) begin
                start_cnt++;
                if (start_at < 0) start_at = n;
            end
            if (mult_erro && erro_at < 0) erro_at = n;
            if (!busy && n > 0) break;
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t tbl[5];
    int   d_at, d_cnt, b_cnt, s_at, s_cnt, e_at;

    task automatic check_normal(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
        check({tag, " done_at"},   32'(d_at),  32'd34);
        check({tag, " done_cnt"},  32'(d_cnt), 32'd1);
        check({tag, " busy_cnt"},  32'(b_cnt), 32'd35);
        check({tag, " start_at"},  32'(s_at),  32'd0);
        check({tag, " start_cnt"}, 32'(s_cnt), 32'd1);
        check({tag, " erro_at"},   32'(e_at),  32'hFFFF_FFFF);
        check({tag, " hi"},        hi_out,     ehi);
        check({tag, " lo"},        lo_out,     elo);
    endtask

    initial begin
        tbl[0] = '{32'd3,          32'd5,          32'h0000_0000, 32'h0000_000F};
        tbl[1] = '{32'hFFFF_FFFF,  32'h0000_0001,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tbl[2] = '{32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000};
        tbl[3] = '{32'hFFFF_FFFD,  32'hFFFF_FFFD,  32'h0000_0000, 32'h0000_0009};
        tbl[4] = '{32'h1234_5678,  32'h0000_0100,  32'h0000_0012, 32'h3456_7800};

        reset = 1'b1; mult_req = 1'b0; hi_write = 1'b0; lo_write = 1'b0; reg_in = '0;
        step();
        step();
        check("rst hi",    hi_out,               32'h0);
        check("rst lo",    lo_out,               32'h0);
        check("rst flags", 32'({mult_start, busy, mult_done, mult_erro}), 32'h0);
        reset = 1'b0;
        step();
        check("idle busy", 32'(busy), 32'h0);

        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i].a, tbl[i].b, d_at, d_cnt, b_cnt, s_at, s_cnt, e_at);
            check_normal($sformatf("vec%0d", i), tbl[i].exp_hi, tbl[i].exp_lo);
        end

        // Reset during WAIT, then 7 * -2.
        op_a = 32'd9; op_b = 32'd9; mult_req = 1'b1;
        step();
        mult_req = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("mid busy", 32'(busy), 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst hi",    hi_out, 32'h0);
        check("midrst lo",    lo_out, 32'h0);
        check("midrst flags", 32'({mult_start, busy, mult_done, mult_erro}), 32'h0);
        step();
        check("midrst idle", 32'(busy), 32'h0);
        run_op(32'd7, 32'hFFFF_FFFE, d_at, d_cnt, b_cnt, s_at, s_cnt, e_at);
        check_normal("neg", 32'hFFFF_FFFF, 32'hFFFF_FFF2);

        // mult_req held 80 cycles; hi_write pulses while busy must be ignored.
        op_a = 32'd6; op_b = 32'd7; mult_req = 1'b1; d_cnt = 0;
        for (int n = 0; n < 80; n++) begin
            step();
            if (mult_done) d_cnt++;
            hi_write = (n == 10 || n == 50);
            reg_in   = 32'hDEAD_BEEF;
        end
        mult_req = 1'b0;
        hi_write = 1'b0;
        for (int n = 0; n < 100 && busy; n++) step();
        check("held dones", 32'(d_cnt), 32'd2);
        check("held idle",  32'(busy),  32'h0);
        check("held hi",    hi_out,     32'h0);
        check("held lo",    lo_out,     32'h0000_002A);

        // IDLE writes.
        hi_write = 1'b1; reg_in = 32'hA5A5_A5A5;
        step();
        hi_write = 1'b0;
        check("mthi hi", hi_out, 32'hA5A5_A5A5);
        check("mthi lo", lo_out, 32'h0000_002A);
        hi_write = 1'b1; lo_write = 1'b1; reg_in = 32'h5A5A_5A5A;
        step();
        hi_write = 1'b0; lo_write = 1'b0;
        check("both hi", hi_out, 32'h5A5A_5A5A);
        check("both lo", lo_out, 32'h5A5A_5A5A);

        // Write coinciding with mult_req is dropped.
        hi_write = 1'b1; reg_in = 32'h1111_1111;
        run_op(32'd2, 32'd3, d_at, d_cnt, b_cnt, s_at, s_cnt, e_at);
        check_normal("req+wr", 32'h0, 32'h0000_0006);

        // Stuck calculando: watchdog abort, HI/LO untouched.
        stuck = 1'b1;
        run_op(32'd9, 32'd9, d_at, d_cnt, b_cnt, s_at, s_cnt, e_at);
        stuck = 1'b0;
        check("wd erro_at",  32'(e_at),  32'd41);
        check("wd done_cnt", 32'(d_cnt), 32'd0);
        check("wd busy_cnt", 32'(b_cnt), 32'd42);
        check("wd hi",       hi_out,     32'h0);
        check("wd lo",       lo_out,     32'h0000_0006);
        check("wd idle",     32'(busy),  32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
